// File: rtl/vsd_slot_if.sv
// SPI bus bundle between the core master, the physical card and the virtual cards.
// The master side drives the core SPI and card MISO lines; the slave side routes them.
interface vsd_slot_if #(
    parameter int SLOTS = 2
);
    logic             spi_sck;
    logic             spi_mosi;
    logic             spi_ss;
    logic             core_miso;
    logic             phy_miso;
    logic             phy_ss;
    logic             phy_sck;
    logic             phy_mosi;
    logic [SLOTS-1:0] vsd_miso;
    logic [SLOTS-1:0] vsd_ss;

    modport master (
        output spi_sck, spi_mosi, spi_ss, phy_miso, vsd_miso,
        input  core_miso, phy_ss, phy_sck, phy_mosi, vsd_ss
    );

    modport slave (
        input  spi_sck, spi_mosi, spi_ss, phy_miso, vsd_miso,
        output core_miso, phy_ss, phy_sck, phy_mosi, vsd_ss
    );
endinterface

// File: rtl/vsd_slot_ctrl.sv
// Multi-slot virtual SD router: mount tracking, SPI routing,
// post-mount cold-reset request and per-path activity indicators.
module vsd_slot_ctrl #(
    parameter int SLOTS       = 2,
    parameter int RST_HOLD    = 10000000,
    parameter int ACT_TIMEOUT = 1000000,
    parameter int CNT_W       = 24,
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [SLOTS-1:0] img_mounted,
    input  logic [SLOTS-1:0] img_nz,
    vsd_slot_if.slave        bus,
    output logic             sel_valid,
    output logic [SW-1:0]    sel_slot,
    output logic             reset_req,
    output logic             act_phys,
    output logic             act_virt
);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] ACT_T   = CNT_W'(ACT_TIMEOUT);

    logic             pend;
    logic             pend_valid;
    logic [SW-1:0]    pend_slot;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] cnt_p;
    logic [CNT_W-1:0] cnt_v;
    logic             prev_mosi;
    logic             prev_miso;

    logic             hit;
    logic [SW-1:0]    hit_idx;
    logic             ej_sel;
    logic             miso_v;
    logic [SLOTS-1:0] vss;
    logic             tog;

    // Descending scan so the lowest strobed index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        ej_sel  = 1'b0;
        miso_v  = 1'b0;
        vss     = '1;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (img_mounted[i] && img_nz[i]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (sel_valid && sel_slot == SW'(i)) begin
                if (img_mounted[i] && !img_nz[i])
                    ej_sel = 1'b1;
                miso_v = bus.vsd_miso[i];
                vss[i] = bus.spi_ss;
            end
        end
    end

    assign bus.phy_ss    = sel_valid | bus.spi_ss;
    assign bus.phy_sck   = bus.spi_sck & ~bus.phy_ss;
    assign bus.phy_mosi  = bus.spi_mosi & ~bus.phy_ss;
    assign bus.vsd_ss    = vss;
    assign bus.core_miso = sel_valid ? miso_v : bus.phy_miso;

    assign tog = (bus.spi_mosi != prev_mosi) ||
                 (bus.core_miso != prev_miso);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pend       <= 1'b0;
            pend_valid <= 1'b0;
            pend_slot  <= '0;
            sel_valid  <= 1'b0;
            sel_slot   <= '0;
        end else if (hit) begin
            pend       <= 1'b1;
            pend_valid <= 1'b1;
            pend_slot  <= hit_idx;
        end else if (ej_sel) begin
            pend       <= 1'b1;
            pend_valid <= 1'b0;
        end else if (pend && bus.spi_ss) begin
            sel_valid  <= pend_valid;
            sel_slot   <= pend_slot;
            pend       <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt   <= '0;
            reset_req <= 1'b0;
        end else if (|img_mounted) begin
            rst_cnt   <= HOLD_M1;
            reset_req <= 1'b1;
        end else if (rst_cnt != '0) begin
            rst_cnt   <= rst_cnt - 1'b1;
        end else begin
            reset_req <= 1'b0;
        end
    end

    // Only the currently routed path is credited with a toggle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_mosi <= 1'b0;
            prev_miso <= 1'b0;
            cnt_p     <= ACT_T;
            cnt_v     <= ACT_T;
            act_phys  <= 1'b0;
            act_virt  <= 1'b0;
        end else begin
            prev_mosi <= bus.spi_mosi;
            prev_miso <= bus.core_miso;
            if (tog && !sel_valid)
                cnt_p <= '0;
            else if (cnt_p < ACT_T)
                cnt_p <= cnt_p + 1'b1;
            if (tog && sel_valid)
                cnt_v <= '0;
            else if (cnt_v < ACT_T)
                cnt_v <= cnt_v + 1'b1;
            act_phys <= (cnt_p < ACT_T);
            act_virt <= (cnt_v < ACT_T);
        end
    end
endmodule

// File: tb/tb_vsd_slot_ctrl.sv
// Scoreboard bench for vsd_slot_ctrl: stimulus queues expected
// observation vectors per cycle, a negedge monitor pops and compares.
module tb_vsd_slot_ctrl;
    localparam logic [10:0] SV  = 11'h400;
    localparam logic [10:0] SL  = 11'h200;
    localparam logic [10:0] RR  = 11'h100;
    localparam logic [10:0] AP  = 11'h080;
    localparam logic [10:0] AV  = 11'h040;
    localparam logic [10:0] CM  = 11'h020;
    localparam logic [10:0] PS  = 11'h010;
    localparam logic [10:0] PK  = 11'h008;
    localparam logic [10:0] PM  = 11'h004;
    localparam logic [10:0] VS  = 11'h003;
    localparam logic [10:0] ALL = 11'h7FF;

    typedef struct {
        int          cyc;
        logic [10:0] mask;
        logic [10:0] val;
        string       name;
    } exp_t;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [1:0] img_mounted;
    logic [1:0] img_nz;
    logic       sel_valid;
    logic [0:0] sel_slot;
    logic       reset_req;
    logic       act_phys;
    logic       act_virt;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    vsd_slot_if #(.SLOTS(2)) bus ();

    vsd_slot_ctrl #(
        .SLOTS(2), .RST_HOLD(4), .ACT_TIMEOUT(8), .CNT_W(24)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .img_mounted(img_mounted), .img_nz(img_nz),
        .bus(bus),
        .sel_valid(sel_valid), .sel_slot(sel_slot),
        .reset_req(reset_req),
        .act_phys(act_phys), .act_virt(act_virt)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int c,
                       input logic [10:0] m, input logic [10:0] v);
        exp_t e;
        e.cyc = c; e.mask = m; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    logic [10:0] obs;
    assign obs = {sel_valid, sel_slot, reset_req, act_phys, act_virt,
                  bus.core_miso, bus.phy_ss, bus.phy_sck,
                  bus.phy_mosi, bus.vsd_ss};

    always @(negedge clk_sys) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                checks++;
                $display("FAIL %s missed cyc=%0d now=%0d",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                checks++;
                if ((obs & sb[i].mask) == (sb[i].val & sb[i].mask))
                    passes++;
                else
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b",
                             sb[i].name, cyc, obs & sb[i].mask,
                             sb[i].val & sb[i].mask, sb[i].mask);
                sb.delete(i);
            end
        end
    end

    int s, t, u, w, x, y, z;

    initial begin
        reset_n = 1'b0;
        img_mounted = '0;
        img_nz = '0;
        bus.spi_sck = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_ss = 1'b1;
        bus.phy_miso = 1'b0;
        bus.vsd_miso = 2'b00;
        tick(2);
        chk("reset", cyc, ALL, PS | VS);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        s = cyc;
        img_mounted = 2'b01; img_nz = 2'b01;
        chk("t1_rr_on", s + 1, RR | SV, RR);
        chk("t1_sel", s + 2, SV | SL | VS | PS, SV | VS | PS);
        chk("t1_rr_hold", s + 4, RR, RR);
        chk("t1_rr_off", s + 5, RR, 11'h000);
        tick(1);
        img_mounted = '0; img_nz = '0;
        tick(5);

        t = cyc;
        bus.spi_ss = 1'b0; bus.spi_sck = 1'b1;
        img_mounted = 2'b10; img_nz = 2'b10;
        chk("t2_vss", t, VS | PS | PK, 11'h002 | PS);
        chk("t2_hold1", t + 1, SV | SL, SV);
        chk("t2_hold3", t + 3, SV | SL, SV);
        tick(1);
        img_mounted = '0; img_nz = '0; bus.spi_sck = 1'b0;
        tick(2);
        bus.spi_ss = 1'b1;
        chk("t2_apply", t + 4, SV | SL | VS, SV | SL | VS);
        tick(2);
        bus.vsd_miso = 2'b10;
        chk("t2_miso", t + 5, CM, CM);
        chk("t2_actv", t + 7, AV | AP, AV);
        tick(3);
        bus.vsd_miso = 2'b00;
        tick(1);

        u = cyc;
        img_mounted = 2'b11; img_nz = 2'b11;
        chk("t3_lowest", u + 2, SV | SL, SV);
        tick(1);
        img_mounted = '0; img_nz = '0;
        tick(2);
        img_mounted = 2'b10; img_nz = 2'b00;
        chk("t3_keep", u + 5, SV | SL, SV);
        chk("t3_retrig", u + 7, RR, RR);
        chk("t3_rr_off", u + 8, RR, 11'h000);
        tick(1);
        img_mounted = '0;
        tick(5);

        w = cyc;
        img_mounted = 2'b01; img_nz = 2'b00;
        chk("t4_eject", w + 2, SV | SL, 11'h000);
        tick(1);
        img_mounted = '0;
        tick(2);
        bus.phy_miso = 1'b1; bus.spi_ss = 1'b0; bus.spi_sck = 1'b1;
        chk("t4_phys", w + 3, CM | PS | PK | VS, CM | PK | VS);
        tick(1);
        bus.spi_sck = 1'b0; bus.spi_mosi = 1'b1; bus.phy_miso = 1'b0;
        chk("t4_mosi", w + 4, CM | PK | PM, PM);
        tick(1);
        bus.spi_mosi = 1'b0; bus.spi_ss = 1'b1;
        tick(14);

        x = cyc;
        chk("t5_idle", x, AP | AV, 11'h000);
        bus.spi_mosi = 1'b1;
        chk("t5_lat", x + 1, AP, 11'h000);
        chk("t5_rise", x + 2, AP, AP);
        chk("t5_virt", x + 5, AV, 11'h000);
        chk("t5_hold", x + 9, AP, AP);
        chk("t5_fall", x + 10, AP, 11'h000);
        tick(12);
        y = cyc;
        bus.spi_mosi = 1'b0;
        tick(5);
        bus.spi_mosi = 1'b1;
        chk("t5_ext", y + 10, AP, AP);
        chk("t5_ext_end", y + 14, AP, AP);
        chk("t5_ext_off", y + 15, AP, 11'h000);
        tick(11);

        z = cyc;
        img_mounted = 2'b10; img_nz = 2'b10;
        chk("t6_pre", z + 2, SV | SL | RR, SV | SL | RR);
        tick(1);
        img_mounted = '0; img_nz = '0;
        tick(2);
        reset_n = 1'b0;
        chk("t6_arst", z + 3, ALL, PS | VS);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        while (sb.size() > 0) begin
            checks++;
            $display("FAIL %s never checked cyc=%0d",
                     sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
